// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with fixed-length burst hold and RETRY/SPLIT handling.
// Optional split masking is compiled in by defining FREEAHB_ARB_SPLIT_EN; without it the split
// mask reads zero and SPLIT behaves like RETRY.
module ahb_arbiter #(
  parameter int unsigned NUM_MGR     = 4,
  parameter int unsigned DEFAULT_MGR = 0
) (
  input  logic                       i_hclk,
  input  logic                       i_hreset,
  input  logic [NUM_MGR-1:0]         i_hbusreq,
  input  logic [1:0]                 i_htrans,
  input  logic [2:0]                 i_hburst,
  input  logic                       i_hready,
  input  logic [1:0]                 i_hresp,
  input  logic [NUM_MGR-1:0]         i_hsplit,
  output logic [NUM_MGR-1:0]         o_hgrant,
  output logic [$clog2(NUM_MGR)-1:0] o_hmaster,
  output logic [$clog2(NUM_MGR)-1:0] o_hmaster_d,
  output logic [NUM_MGR-1:0]         o_split_mask
);

  localparam int unsigned IdxW = $clog2(NUM_MGR);

  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [1:0] RespRetry   = 2'b10;
  localparam logic [1:0] RespSplit   = 2'b11;
  localparam logic [2:0] BurstIncr4  = 3'b011;
  localparam logic [2:0] BurstIncr8  = 3'b101;
  localparam logic [2:0] BurstIncr16 = 3'b111;

  localparam logic [IdxW-1:0]    DefIdx  = IdxW'(DEFAULT_MGR);
  localparam logic [NUM_MGR-1:0] OneHot0 = NUM_MGR'(1);

  typedef enum logic [1:0] {StPark, StOwn, StBurst} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    data_owner_q;
  logic [NUM_MGR-1:0] mask_q, mask_d;

  logic [NUM_MGR-1:0] cand;
  logic               force_arb;
  logic               abort_resp;
  logic               burst_start;
  logic               burst_last;
  logic               arb;
  logic [3:0]         burst_len;
  logic               found;
  logic [IdxW-1:0]    pick;
  logic [IdxW-1:0]    scan;

  // Both RETRY and SPLIT cancel whatever burst is in flight.
  assign abort_resp = (i_hresp == RespRetry) || (i_hresp == RespSplit);

`ifdef FREEAHB_ARB_SPLIT_EN
  logic [NUM_MGR-1:0] split_set;

  // First SPLIT cycle parks the data-phase owner; a release on the same edge loses to the set.
  assign split_set = (i_hresp == RespSplit && !i_hready) ? (OneHot0 << data_owner_q) : '0;
  assign mask_d    = (mask_q & ~i_hsplit) | split_set;
  // The newly split manager must already be excluded from the forced handover.
  assign cand      = i_hbusreq & ~(mask_q | split_set);
  assign force_arb = |split_set;
`else
  logic unused_hsplit;

  assign unused_hsplit = ^i_hsplit;
  assign mask_d        = '0;
  assign cand          = i_hbusreq;
  assign force_arb     = 1'b0;
`endif

  // cnt_q holds the SEQ beats still owed; the accepted SEQ that takes it to zero ends the burst.
  assign burst_len   = (i_hburst == BurstIncr4) ? 4'd3 :
                       (i_hburst == BurstIncr8) ? 4'd7 : 4'd15;
  assign burst_start = i_hready && (state_q != StBurst) && (i_htrans == TransNonseq) &&
                       !abort_resp && (i_hburst inside {BurstIncr4, BurstIncr8, BurstIncr16});
  assign burst_last  = (state_q == StBurst) && i_hready && (i_htrans == TransSeq) &&
                       (cnt_q <= 4'd1);
  assign arb         = (i_hready && (state_q != StBurst)) || burst_last || force_arb ||
                       (i_hready && abort_resp);

  // Round-robin scan starting just after the current owner; the owner itself is tried last.
  always_comb begin
    found = 1'b0;
    pick  = DefIdx;
    scan  = owner_q;
    for (int unsigned k = 0; k < NUM_MGR; k++) begin
      scan = (scan == IdxW'(NUM_MGR - 1)) ? '0 : scan + IdxW'(1);
      if (!found && cand[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  // Next owner, FSM state and beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if ((state_q == StBurst) && i_hready && (i_htrans == TransSeq) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (abort_resp) begin
      cnt_d = '0;
      if (state_q == StBurst) begin
        state_d = StOwn;
      end
    end
    if (arb) begin
      if (found) begin
        owner_d = pick;
        state_d = StOwn;
      end else begin
        owner_d = DefIdx;
        state_d = StPark;
      end
    end
    // An accepted fixed-length NONSEQ locks the current owner in for the whole burst.
    if (burst_start) begin
      owner_d = owner_q;
      state_d = StBurst;
      cnt_d   = burst_len;
    end
  end

  // State registers; data-phase owner follows the address phase on every accepted transfer.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state_q      <= StPark;
      cnt_q        <= '0;
      owner_q      <= DefIdx;
      data_owner_q <= DefIdx;
      mask_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      if (i_hready) begin
        data_owner_q <= owner_q;
      end
    end
  end

  assign o_hgrant     = OneHot0 << owner_q;
  assign o_hmaster    = owner_q;
  assign o_hmaster_d  = data_owner_q;
  assign o_split_mask = mask_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed vector table for ahb_arbiter (4 managers, default 0), plus a
// hand-written asynchronous reset in the middle of an INCR16 burst.
module tb_ahb_arbiter;

  localparam logic [1:0] TrIdle = 2'd0, TrBusy = 2'd1, TrNs = 2'd2, TrSeq = 2'd3;
  localparam logic [2:0] BSingle = 3'd0, BIncr = 3'd1, BIncr4 = 3'd3, BIncr8 = 3'd5;
  localparam logic [2:0] BIncr16 = 3'd7;
  localparam logic [1:0] ROk = 2'd0, RErr = 2'd1, RRetry = 2'd2, RSplit = 2'd3;

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [1:0] resp;
    logic [3:0] hsplit;
    logic [1:0] own;
    logic [1:0] hmd;
    logic [3:0] mask;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] busreq = '0;
  logic [1:0] htrans = '0;
  logic [2:0] hburst = '0;
  logic       hready = 1'b1;
  logic [1:0] hresp = '0;
  logic [3:0] hsplit = '0;
  logic [3:0] o_hgrant;
  logic [1:0] o_hmaster;
  logic [1:0] o_hmaster_d;
  logic [3:0] o_split_mask;

  int n_checks = 0;
  int n_fail   = 0;
  int vec_id   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ahb_arbiter #(
    .NUM_MGR    (4),
    .DEFAULT_MGR(0)
  ) dut (
    .i_hclk      (clk),
    .i_hreset    (rst),
    .i_hbusreq   (busreq),
    .i_htrans    (htrans),
    .i_hburst    (hburst),
    .i_hready    (hready),
    .i_hresp     (hresp),
    .i_hsplit    (hsplit),
    .o_hgrant    (o_hgrant),
    .o_hmaster   (o_hmaster),
    .o_hmaster_d (o_hmaster_d),
    .o_split_mask(o_split_mask)
  );

  function automatic vec_t mk(input logic [3:0] req, input logic [1:0] trans,
                              input logic [2:0] burst, input logic rdy, input logic [1:0] resp,
                              input logic [3:0] hs, input logic [1:0] own,
                              input logic [1:0] hmd, input logic [3:0] mask);
    vec_t v;
    v.req = req; v.trans = trans; v.burst = burst; v.rdy = rdy; v.resp = resp;
    v.hsplit = hs; v.own = own; v.hmd = hmd; v.mask = mask;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, vec_id, got, exp);
    end
  endtask

  task automatic check_outs(input logic [1:0] own, input logic [1:0] hmd,
                            input logic [3:0] mask);
    logic [3:0] g;
    g = 4'b0001 << own;
    check("hgrant", 32'(o_hgrant), 32'(g));
    check("hmaster", 32'(o_hmaster), 32'(own));
    check("hmaster_d", 32'(o_hmaster_d), 32'(hmd));
    check("split_mask", 32'(o_split_mask), 32'(mask));
  endtask

  task automatic run_vec(input vec_t v);
    busreq = v.req;
    htrans = v.trans;
    hburst = v.burst;
    hready = v.rdy;
    hresp  = v.resp;
    hsplit = v.hsplit;
    @(posedge clk);
    #1;
    check_outs(v.own, v.hmd, v.mask);
    vec_id++;
  endtask

  initial begin
    // Rotation with all four requesting single INCR transfers.
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(4'hF, TrNs, BIncr, 1'b1, ROk, 4'h0, 2'((i + 1) % 4), 2'(i), 4'h0));
    end
    // Three wait states at an arbitration point, then handover.
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(4'h2, TrIdle, BSingle, 1'b0, ROk, 4'h0, 2'd0, 2'd3, 4'h0));
    end
    vecs.push_back(mk(4'h2, TrIdle, BSingle, 1'b1, ROk, 4'h0, 2'd1, 2'd0, 4'h0));
    // INCR8 from mgr1 with one BUSY and one wait state; mgr2 waits for the last beat.
    vecs.push_back(mk(4'h6, TrNs,   BIncr8, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrSeq,  BIncr8, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrSeq,  BIncr8, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrBusy, BIncr8, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrSeq,  BIncr8, 1'b0, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(4'h6, TrSeq, BIncr8, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    end
    vecs.push_back(mk(4'h6, TrSeq,  BIncr8, 1'b1, ROk, 4'h0, 2'd2, 2'd1, 4'h0));
    // Retention, request drop, park, ERROR ignored.
    vecs.push_back(mk(4'h4, TrNs,   BIncr,   1'b1, ROk,  4'h0, 2'd2, 2'd2, 4'h0));
    vecs.push_back(mk(4'h8, TrNs,   BIncr,   1'b1, ROk,  4'h0, 2'd3, 2'd2, 4'h0));
    vecs.push_back(mk(4'h0, TrIdle, BSingle, 1'b1, ROk,  4'h0, 2'd0, 2'd3, 4'h0));
    vecs.push_back(mk(4'h0, TrIdle, BSingle, 1'b1, ROk,  4'h0, 2'd0, 2'd0, 4'h0));
    vecs.push_back(mk(4'h2, TrIdle, BSingle, 1'b0, RErr, 4'h0, 2'd0, 2'd0, 4'h0));
    vecs.push_back(mk(4'h2, TrIdle, BSingle, 1'b1, RErr, 4'h0, 2'd1, 2'd0, 4'h0));
    // RETRY aborts an INCR4 after one SEQ; handover on the second response cycle.
    vecs.push_back(mk(4'h6, TrNs,   BIncr4,  1'b1, ROk,    4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrSeq,  BIncr4,  1'b1, ROk,    4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrSeq,  BIncr4,  1'b0, RRetry, 4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b1, RRetry, 4'h0, 2'd2, 2'd1, 4'h0));
    vecs.push_back(mk(4'h4, TrIdle, BSingle, 1'b1, ROk,    4'h0, 2'd2, 2'd2, 4'h0));
`ifdef FREEAHB_ARB_SPLIT_EN
    // SPLIT to data-phase mgr2: masked and skipped until its release pulse.
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b0, RSplit, 4'h0, 2'd1, 2'd2, 4'h4));
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b1, RSplit, 4'h0, 2'd1, 2'd1, 4'h4));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(4'h6, TrNs, BIncr, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h4));
    end
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h4, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h0, 2'd2, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h0, 2'd1, 2'd2, 4'h0));
    // Set and release of the same bit on one edge: set wins.
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b0, RSplit, 4'h4, 2'd1, 2'd2, 4'h4));
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b1, RSplit, 4'h0, 2'd1, 2'd1, 4'h4));
    vecs.push_back(mk(4'h0, TrIdle, BSingle, 1'b1, ROk,    4'h0, 2'd0, 2'd1, 4'h4));
    vecs.push_back(mk(4'h0, TrIdle, BSingle, 1'b1, ROk,    4'h4, 2'd0, 2'd0, 4'h0));
`else
    // SPLIT acts as RETRY and i_hsplit is ignored; the mask stays zero.
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b0, RSplit, 4'h0, 2'd2, 2'd2, 4'h0));
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b1, RSplit, 4'h0, 2'd1, 2'd2, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h0, 2'd2, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h0, 2'd1, 2'd2, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h0, 2'd2, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h4, 2'd1, 2'd2, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h0, 2'd2, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrNs,   BIncr,   1'b1, ROk,    4'h0, 2'd1, 2'd2, 4'h0));
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b0, RSplit, 4'h4, 2'd1, 2'd2, 4'h0));
    vecs.push_back(mk(4'h6, TrIdle, BSingle, 1'b1, RSplit, 4'h0, 2'd2, 2'd1, 4'h0));
    vecs.push_back(mk(4'h0, TrIdle, BSingle, 1'b1, ROk,    4'h0, 2'd0, 2'd2, 4'h0));
    vecs.push_back(mk(4'h0, TrIdle, BSingle, 1'b1, ROk,    4'h4, 2'd0, 2'd0, 4'h0));
`endif
    // Lead-in to an INCR16 from mgr1 that gets reset part-way.
    vecs.push_back(mk(4'h2, TrIdle, BSingle, 1'b1, ROk, 4'h0, 2'd1, 2'd0, 4'h0));
    vecs.push_back(mk(4'h2, TrNs,   BIncr16, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrSeq,  BIncr16, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));
    vecs.push_back(mk(4'h6, TrSeq,  BIncr16, 1'b1, ROk, 4'h0, 2'd1, 2'd1, 4'h0));

    // Reset state while reset is held.
    @(posedge clk);
    #1;
    check_outs(2'd0, 2'd0, 4'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset between edges, mid-INCR16: outputs return to reset values at once.
    #2;
    rst = 1'b1;
    #1;
    check_outs(2'd0, 2'd0, 4'h0);
    @(posedge clk);
    #1;
    check_outs(2'd0, 2'd0, 4'h0);
    rst = 1'b0;
    // A further SEQ must not be treated as a burst beat: the FSM is back in PARK.
    run_vec(mk(4'h6, TrSeq, BIncr16, 1'b1, ROk, 4'h0, 2'd1, 2'd0, 4'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
